// File: rtl/tank_ctrl_p.sv
// Per-player tank controller: frame-tick movement with wall clamping,
// rate-limited fire pulse and the sprite hit test for the colour mapper.
module tank_ctrl_p #(
  parameter logic [9:0] X_START   = 10'd500,
  parameter logic [9:0] Y_START   = 10'd240,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] Y_MAX     = 10'd479,
  parameter logic [9:0] STEP      = 10'd1,
  parameter logic [9:0] SIZE      = 10'd32,
  parameter logic [7:0] COOLDOWN  = 8'd30,
  parameter logic [7:0] KEY_UP    = 8'h1A,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_FIRE  = 8'h58
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_tank,
  output logic [9:0] tank_X,
  output logic [9:0] tank_Y,
  output logic [2:0] tank_dir,
  output logic       fire_pulse,
  output logic       fire_ready,
  output logic       moving
);

  typedef enum logic [1:0] {READY, COOL, REARM} fire_state_e;

  logic        fc_meta_q, fc_sync_q, fc_prev_q;
  logic        tick;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  dir_q, dir_d;
  logic        moving_q, moving_d;
  logic [10:0] x_far, y_far;
  logic [9:0]  x_lim, y_lim;
  logic        fire_key;

  fire_state_e state_q;
  logic [7:0]  cnt_q;
  logic        fire_pulse_q, fire_ready_q;

  // frame_clk is asynchronous to Clk; tick is the synchronised rising edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_meta_q <= 1'b0;
      fc_sync_q <= 1'b0;
      fc_prev_q <= 1'b0;
    end else begin
      fc_meta_q <= frame_clk;
      fc_sync_q <= fc_meta_q;
      fc_prev_q <= fc_sync_q;
    end
  end

  assign tick     = fc_sync_q & ~fc_prev_q;
  assign fire_key = (keycode == KEY_FIRE);

  // Far edge after a step, in 11 bits so X_MAX/Y_MAX near 1023 cannot wrap
  assign x_far = {1'b0, x_q} + {1'b0, STEP} + {1'b0, SIZE} - 11'd1;
  assign y_far = {1'b0, y_q} + {1'b0, STEP} + {1'b0, SIZE} - 11'd1;
  assign x_lim = X_MAX - SIZE + 10'd1;
  assign y_lim = Y_MAX - SIZE + 10'd1;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    if (tick) begin
      if (keycode == KEY_UP) begin
        y_d   = (y_q < STEP) ? 10'd0 : y_q - STEP;
        dir_d = 3'b001;
      end else if (keycode == KEY_DOWN) begin
        y_d   = (y_far > {1'b0, Y_MAX}) ? y_lim : y_q + STEP;
        dir_d = 3'b100;
      end else if (keycode == KEY_LEFT) begin
        x_d   = (x_q < STEP) ? 10'd0 : x_q - STEP;
        dir_d = 3'b011;
      end else if (keycode == KEY_RIGHT) begin
        x_d   = (x_far > {1'b0, X_MAX}) ? x_lim : x_q + STEP;
        dir_d = 3'b010;
      end
      moving_d = (x_d != x_q) || (y_d != y_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q      <= X_START;
      y_q      <= Y_START;
      dir_q    <= 3'b001;
      moving_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
    end
  end

  // REARM forces a release between shots, so a held key never auto-repeats
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= READY;
      cnt_q        <= 8'd0;
      fire_pulse_q <= 1'b0;
      fire_ready_q <= 1'b1;
    end else begin
      fire_pulse_q <= 1'b0;
      if (tick) begin
        case (state_q)
          READY: if (fire_key) begin
            fire_pulse_q <= 1'b1;
            fire_ready_q <= 1'b0;
            cnt_q        <= COOLDOWN;
            state_q      <= COOL;
          end
          COOL: begin
            if (cnt_q <= 8'd1) begin
              cnt_q <= 8'd0;
              if (fire_key) begin
                state_q <= REARM;
              end else begin
                state_q      <= READY;
                fire_ready_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          REARM: if (!fire_key) begin
            state_q      <= READY;
            fire_ready_q <= 1'b1;
          end
          default: begin
            state_q      <= READY;
            fire_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign is_tank = ({1'b0, DrawX} >= {1'b0, x_q}) &&
                   ({1'b0, DrawX} <= {1'b0, x_q} + {1'b0, SIZE} - 11'd1) &&
                   ({1'b0, DrawY} >= {1'b0, y_q}) &&
                   ({1'b0, DrawY} <= {1'b0, y_q} + {1'b0, SIZE} - 11'd1);

  assign tank_X     = x_q;
  assign tank_Y     = y_q;
  assign tank_dir   = dir_q;
  assign moving     = moving_q;
  assign fire_pulse = fire_pulse_q;
  assign fire_ready = fire_ready_q;

endmodule
